pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised inter-stage pipeline register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed 32-bit enable/flush stage registers between IF/ID, ID/EX, EX/MEM and MEM/WB. It adds:
- back-pressure without a combinational ready path;
- a configurable bubble value loaded on flush;
- a saturating stall counter for performance monitoring.

## Interface
Parameters:
- WIDTH, 64, payload width in bits (e.g. PC+4 concatenated with the instruction word).
- FLUSH_VAL, {WIDTH{1'b0}}, payload loaded on reset and flush (NOP bubble).
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; highest priority after reset.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  block can accept a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  payload presented downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  downstream payload.
- level  output  2  occupancy: 0, 1 or 2.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Storage:
  - main register (main_data, main_v) drives out_data/out_valid;
  - skid register (skid_data, skid_v).
- Handshakes:
  - in_fire = in_valid & in_ready;
  - out_fire = out_valid & out_ready.
- States, encoded by (main_v, skid_v):
  - EMPTY (0,0);
  - ONE (1,0);
  - FULL (1,1).
  - (0,1) is illegal and never reached.
- in_ready = (state != FULL). It is a pure function of registered state, with no combinational path from out_ready. out_valid = main_v. level = main_v + skid_v.
- Transitions, when flush=0:
  - EMPTY:
    - in_fire: main ← in_data, go to ONE.
    - Otherwise stay. main_data holds its value.
  - ONE:
    - in_fire & out_fire: main ← in_data, stay in ONE.
    - in_fire only: skid ← in_data, go to FULL.
    - out_fire only: go to EMPTY. main_data keeps the last value.
    - Neither: hold.
  - FULL:
    - in_fire is impossible (in_ready=0).
    - out_fire: main ← skid_data, skid_v ← 0, go to ONE.
    - Otherwise hold.
- Flush (flush=1 at a clock edge):
  - main_v and skid_v are cleared; state becomes EMPTY.
  - main_data ← FLUSH_VAL; skid_data ← FLUSH_VAL.
  - Any in_fire in the same cycle is discarded.
  - Any out_fire in the same cycle completes downstream; the block itself just empties.
- Reset (rst_n=0, asynchronous):
  - state EMPTY; main_data = skid_data = FLUSH_VAL;
  - stall_cnt = 0.
  - Reset mid-transfer discards all contents immediately, without waiting for a clock edge.
- stall_cnt:
  - Increments at each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; it never wraps.
  - Cleared only by reset. Flush does not clear it.
  - The flush cycle itself counts if the stall condition held in that cycle.
- Ordering: payloads leave strictly in acceptance order. Nothing is duplicated or lost, except by flush or reset.

## Timing
- Latency is one cycle: a payload accepted at edge N is on out_data, with out_valid=1, after edge N.
- Throughput is one payload per cycle while out_ready=1.
- in_ready falls the cycle after the skid register fills. The one payload accepted in the cycle where out_ready dropped goes into the skid register.
- After a flush edge: out_valid=0 and in_ready=1 from the next cycle, and out_data=FLUSH_VAL.
- Output values after reset release: out_valid=0, in_ready=1, out_data=FLUSH_VAL, level=0, stall_cnt=0.
- All outputs are registered or decoded from registered state only; none combinationally depends on any input.

## Test plan
Use WIDTH=32, FLUSH_VAL=32'h00000013, CNT_W=4.
1. Streaming, no back-pressure:
   - Stimulus: out_ready=1; feed 0x1,0x2,0x3 on consecutive cycles.
   - Required: out_data shows 0x1,0x2,0x3 one cycle later each; level stays at or below 1; in_ready stays 1.
2. Skid fill and drain:
   - Stimulus: out_ready=0 while 0xA then 0xB are offered.
   - Required: level=2; in_ready=0; 0xC is held off upstream; out_data=0xA.
   - Stimulus: raise out_ready.
   - Required: outputs 0xA, 0xB, then 0xC in order.
3. Flush with simultaneous input:
   - Stimulus: level=2; assert flush together with in_valid=1, in_data=0xD.
   - Required, next cycle: out_valid=0, level=0, out_data=0x00000013, in_ready=1.
   - Required afterwards: 0xD never appears.
4. Async reset mid-operation:
   - Stimulus: drop rst_n between clock edges with level=1.
   - Required: out_valid=0 and stall_cnt=0 immediately, with no edge needed.
5. Stall counter saturation:
   - Stimulus: hold out_valid=1, out_ready=0 for 20 cycles.
   - Required: stall_cnt reaches 15 and stays there; a flush leaves it at 15.
6. Random back-pressure:
   - Stimulus: 1000 random in_valid/out_ready cycles, checked against a scoreboard.
   - Required: in-order, lossless delivery, and (main_v, skid_v) is never (0,1).

Source files
------------

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between pipeline stages: upstream (in_*) and downstream (out_*) sides.
// A payload transfers on a rising edge where valid and ready are both 1; the data sits
// with its valid, and ready never depends combinationally on the opposite side's valid.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // slave: the pipeline register itself; master: whatever drives and consumes it
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with a two-entry skid buffer, flush-to-bubble and a
// saturating stall counter. All outputs decode from registered state only.
module pipe_skid_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_skid_reg_if.slave   bus,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] stall_cnt
);

  // Encoding is {main_v, skid_v}, so the unreachable (0,1) pattern has no name.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [CNT_W-1:0] stall_q;

  logic in_fire;
  logic out_fire;

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = state_q[1];
  assign bus.out_data  = main_q;
  assign level         = {1'b0, state_q[1]} + {1'b0, state_q[0]};
  assign stall_cnt     = stall_q;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_VAL;
      skid_q  <= FLUSH_VAL;
      stall_q <= '0;
    end else begin
      // Counts independently of flush so the flush cycle itself is included.
      if (bus.out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end

      if (flush) begin
        state_q <= EMPTY;
        main_q  <= FLUSH_VAL;
        skid_q  <= FLUSH_VAL;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              main_q  <= bus.in_data;
              state_q <= ONE;
            end
          end
          ONE: begin
            case ({in_fire, out_fire})
              2'b11: main_q <= bus.in_data;
              2'b10: begin
                skid_q  <= bus.in_data;
                state_q <= FULL;
              end
              2'b01: state_q <= EMPTY;
              default: state_q <= ONE;
            endcase
          end
          FULL: begin
            if (out_fire) begin
              main_q  <= skid_q;
              state_q <= ONE;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random back-pressure, all checked
// each cycle against a queue model of the block's contents.
module tb_pipe_skid_reg;

  localparam int          WIDTH     = 32;
  localparam logic [31:0] FLUSH_VAL = 32'h0000_0013;
  localparam int          CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       level;
  logic [CNT_W-1:0] stall_cnt;

  pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

  pipe_skid_reg #(
    .WIDTH     (WIDTH),
    .FLUSH_VAL (FLUSH_VAL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .level     (level),
    .stall_cnt (stall_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] hold_val = FLUSH_VAL;
  int               m_stall  = 0;
  int               errors   = 0;
  int               checks   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the DUT against the model between edges, then advances the model with
  // what the upcoming rising edge will do given the inputs now held stable.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_val = FLUSH_VAL;
      m_stall  = 0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_level",     32'(level),         32'd0);
      check("rst_stall_cnt", 32'(stall_cnt),     32'd0);
      check("rst_out_data",  bus.out_data,       FLUSH_VAL);
    end else begin
      int  n;
      logic of, inf;
      n = exp_q.size();
      check("level",     32'(level),         32'(n));
      check("out_valid", 32'(bus.out_valid), 32'(n > 0));
      check("in_ready",  32'(bus.in_ready),  32'(n < 2));
      check("out_data",  bus.out_data,       (n > 0) ? exp_q[0] : hold_val);
      check("stall_cnt", 32'(stall_cnt),     32'(m_stall));

      of  = (n > 0) && bus.out_ready;
      inf = bus.in_valid && (n < 2);
      if (n > 0 && !bus.out_ready && m_stall < CNT_MAX) m_stall++;
      if (of) hold_val = exp_q.pop_front();
      if (flush) begin
        exp_q.delete();
        hold_val = FLUSH_VAL;
      end else if (inf) begin
        exp_q.push_back(bus.in_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers d until accepted; in_ready is registered so its value before the edge decides.
  task automatic send(input logic [WIDTH-1:0] d);
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 50; k++) begin
      acc = bus.in_ready;
      step();
      if (acc) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    $display("FAIL send_timeout: got 0x%08h not accepted, expected acceptance within 50 cycles", d);
    $fatal(1, "send timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset release away from the rising edge
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    step(2);

    // streaming without back-pressure
    bus.out_ready = 1'b1;
    send(32'h1);
    send(32'h2);
    send(32'h3);
    step(3);

    // skid fill, upstream held off, then drain in order
    bus.out_ready = 1'b0;
    send(32'hA);
    send(32'hB);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hC;
    step(3);
    bus.out_ready = 1'b1;
    send(32'hC);
    step(3);

    // flush while full with a simultaneous input that must be dropped
    bus.out_ready = 1'b0;
    send(32'h21);
    send(32'h22);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hD;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    step(2);
    bus.out_ready = 1'b1;
    step(3);

    // asynchronous reset between edges while holding one payload
    bus.out_ready = 1'b0;
    send(32'h44);
    step();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(2);

    // stall counter saturation, unaffected by flush
    bus.out_ready = 1'b0;
    send(32'h55);
    step(20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(2);
    bus.out_ready = 1'b1;
    step(2);

    // random back-pressure with occasional flush
    for (int i = 0; i < 1000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 63) == 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
